// File: rtl/prescale_div_ctrl.sv
// PRESCALE handshake, ratio decode and divide counter for the UART RX oversampling divider.
// Define PRESCALE_EXT_RATIO_EN to make codes 6'b000010 (16) and 6'b000001 (32) legal.
module prescale_div_ctrl #(
  parameter int unsigned PRESCALE_WIDTH = 6,
  parameter int unsigned RATIO_WIDTH    = 8
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      CLK_EN,
  input  logic                      CFG_VALID,
  input  logic [PRESCALE_WIDTH-1:0] PRESCALE,
  output logic                      CFG_READY,
  output logic                      CFG_DONE,
  output logic                      CFG_ERR,
  output logic [RATIO_WIDTH-1:0]    DIV_RATIO,
  output logic                      DIV_TICK,
  output logic                      DIV_OUT
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PEND
  } state_t;

  localparam logic [PRESCALE_WIDTH-1:0] PS_DIV1  = PRESCALE_WIDTH'(6'b100000);
  localparam logic [PRESCALE_WIDTH-1:0] PS_DIV2  = PRESCALE_WIDTH'(6'b010000);
  localparam logic [PRESCALE_WIDTH-1:0] PS_DIV4  = PRESCALE_WIDTH'(6'b001000);
  localparam logic [PRESCALE_WIDTH-1:0] PS_DIV8  = PRESCALE_WIDTH'(6'b000100);
`ifdef PRESCALE_EXT_RATIO_EN
  localparam logic [PRESCALE_WIDTH-1:0] PS_DIV16 = PRESCALE_WIDTH'(6'b000010);
  localparam logic [PRESCALE_WIDTH-1:0] PS_DIV32 = PRESCALE_WIDTH'(6'b000001);
`endif

  state_t                 state_q;
  logic [RATIO_WIDTH-1:0] cnt_q;
  logic [RATIO_WIDTH-1:0] ratio_q;
  logic [RATIO_WIDTH-1:0] pend_q;
  logic                   tick_q;
  logic                   done_q;
  logic                   err_q;

  logic                   accept;
  logic                   wrap;
  logic                   dec_legal;
  logic [RATIO_WIDTH-1:0] dec_ratio;

  always_comb begin
    dec_legal = 1'b1;
    dec_ratio = RATIO_WIDTH'(1);
    if (PRESCALE == PS_DIV1)       dec_ratio = RATIO_WIDTH'(1);
    else if (PRESCALE == PS_DIV2)  dec_ratio = RATIO_WIDTH'(2);
    else if (PRESCALE == PS_DIV4)  dec_ratio = RATIO_WIDTH'(4);
    else if (PRESCALE == PS_DIV8)  dec_ratio = RATIO_WIDTH'(8);
`ifdef PRESCALE_EXT_RATIO_EN
    else if (PRESCALE == PS_DIV16) dec_ratio = RATIO_WIDTH'(16);
    else if (PRESCALE == PS_DIV32) dec_ratio = RATIO_WIDTH'(32);
`endif
    else                           dec_legal = 1'b0;
  end

  assign CFG_READY = (state_q != S_PEND);
  assign accept    = CFG_VALID && CFG_READY;
  assign wrap      = (cnt_q == ratio_q - RATIO_WIDTH'(1));

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ratio_q <= RATIO_WIDTH'(1);
      pend_q  <= '0;
      tick_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= accept && !dec_legal;
      case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          if (accept && dec_legal) begin
            ratio_q <= dec_ratio;
            done_q  <= 1'b1;
          end
          if (CLK_EN) state_q <= S_RUN;
        end
        S_RUN: begin
          if (!CLK_EN) begin
            // An accept on the disabling edge behaves like an IDLE accept.
            state_q <= S_IDLE;
            cnt_q   <= '0;
            if (accept && dec_legal) begin
              ratio_q <= dec_ratio;
              done_q  <= 1'b1;
            end
          end else begin
            if (wrap) begin
              cnt_q  <= '0;
              tick_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + RATIO_WIDTH'(1);
            end
            if (accept && dec_legal) begin
              if (dec_ratio == ratio_q) begin
                done_q <= 1'b1;
              end else begin
                pend_q  <= dec_ratio;
                state_q <= S_PEND;
              end
            end
          end
        end
        S_PEND: begin
          if (!CLK_EN) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ratio_q <= pend_q;
            done_q  <= 1'b1;
          end else if (wrap) begin
            // Swap ratio only at the period boundary so no period is cut or stretched.
            cnt_q   <= '0;
            tick_q  <= 1'b1;
            ratio_q <= pend_q;
            done_q  <= 1'b1;
            state_q <= S_RUN;
          end else begin
            cnt_q <= cnt_q + RATIO_WIDTH'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign CFG_DONE  = done_q;
  assign CFG_ERR   = err_q;
  assign DIV_RATIO = ratio_q;
  assign DIV_TICK  = tick_q;
  assign DIV_OUT   = (state_q != S_IDLE) &&
                     ((ratio_q == RATIO_WIDTH'(1)) || (cnt_q < (ratio_q >> 1)));

endmodule

// File: tb/tb_prescale_div_ctrl.sv
// Table-driven scoreboard bench for prescale_div_ctrl; honours PRESCALE_EXT_RATIO_EN.
module tb_prescale_div_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic       CLK_EN;
  logic       CFG_VALID;
  logic [5:0] PRESCALE;
  logic       CFG_READY;
  logic       CFG_DONE;
  logic       CFG_ERR;
  logic [7:0] DIV_RATIO;
  logic       DIV_TICK;
  logic       DIV_OUT;

  prescale_div_ctrl #(
    .PRESCALE_WIDTH(6),
    .RATIO_WIDTH   (8)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .CLK_EN   (CLK_EN),
    .CFG_VALID(CFG_VALID),
    .PRESCALE (PRESCALE),
    .CFG_READY(CFG_READY),
    .CFG_DONE (CFG_DONE),
    .CFG_ERR  (CFG_ERR),
    .DIV_RATIO(DIV_RATIO),
    .DIV_TICK (DIV_TICK),
    .DIV_OUT  (DIV_OUT)
  );

  always #5 CLK = ~CLK;

  // Packed expectation: {ready, done, err, ratio[7:0], tick, out}
  typedef struct {
    logic        rst;
    logic        en;
    logic        v;
    logic [5:0]  ps;
    logic [12:0] exp;
  } vec_t;

  vec_t        vecs[$];
  logic [12:0] sb[$];
  int          n_checks = 0;
  int          n_pass   = 0;

`ifdef PRESCALE_EXT_RATIO_EN
  localparam logic [7:0] R_AFTER_EXT = 8'd32;
`else
  localparam logic [7:0] R_AFTER_EXT = 8'd4;
`endif

  function automatic void add(input logic rst, en, v, input logic [5:0] ps,
                              input logic rdy, done, err, input logic [7:0] ratio,
                              input logic tick, out);
    vec_t t;
    t.rst = rst; t.en = en; t.v = v; t.ps = ps;
    t.exp = {rdy, done, err, ratio, tick, out};
    vecs.push_back(t);
  endfunction

  task automatic check(input string name, input logic [12:0] act, input logic [12:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got rdy=%b done=%b err=%b ratio=%0d tick=%b out=%b, want rdy=%b done=%b err=%b ratio=%0d tick=%b out=%b",
                  name, act[12], act[11], act[10], act[9:2], act[1], act[0],
                  exp[12], exp[11], exp[10], exp[9:2], exp[1], exp[0]);
  endtask

  task automatic apply(input vec_t t, input string name);
    logic [12:0] exp;
    @(negedge CLK);
    RST = t.rst; CLK_EN = t.en; CFG_VALID = t.v; PRESCALE = t.ps;
    sb.push_back(t.exp);
    @(posedge CLK);
    #1;
    if (sb.size() == 0) begin
      n_checks++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      exp = sb.pop_front();
      check(name, {CFG_READY, CFG_DONE, CFG_ERR, DIV_RATIO, DIV_TICK, DIV_OUT}, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t t;
    RST = 1'b1; CLK_EN = 1'b0; CFG_VALID = 1'b0; PRESCALE = '0;
    repeat (2) @(posedge CLK);
    #1;
    check("reset", {CFG_READY, CFG_DONE, CFG_ERR, DIV_RATIO, DIV_TICK, DIV_OUT},
          {1'b1, 1'b0, 1'b0, 8'd1, 1'b0, 1'b0});

    // Ratio 1 default: tick every edge after RUN entry, level constantly high
    add(0,1,0,6'b000000, 1,0,0,8'd1,0,1);
    add(0,1,0,6'b000000, 1,0,0,8'd1,1,1);
    add(0,1,0,6'b000000, 1,0,0,8'd1,1,1);
    add(0,1,0,6'b000000, 1,0,0,8'd1,1,1);
    add(0,0,0,6'b000000, 1,0,0,8'd1,0,0);
    // Ratio 4 configured in IDLE
    add(0,0,1,6'b001000, 1,1,0,8'd4,0,0);
    add(0,1,0,6'b000000, 1,0,0,8'd4,0,1);
    add(0,1,0,6'b000000, 1,0,0,8'd4,0,1);
    add(0,1,0,6'b000000, 1,0,0,8'd4,0,0);
    add(0,1,0,6'b000000, 1,0,0,8'd4,0,0);
    add(0,1,0,6'b000000, 1,0,0,8'd4,1,1);
    add(0,1,0,6'b000000, 1,0,0,8'd4,0,1);
    add(0,1,0,6'b000000, 1,0,0,8'd4,0,0);
    add(0,1,0,6'b000000, 1,0,0,8'd4,0,0);
    add(0,1,0,6'b000000, 1,0,0,8'd4,1,1);
    // Illegal code while running: error pulse, spacing unchanged
    add(0,1,1,6'b000011, 1,0,1,8'd4,0,1);
    add(0,1,0,6'b000000, 1,0,0,8'd4,0,0);
    add(0,1,0,6'b000000, 1,0,0,8'd4,0,0);
    add(0,1,0,6'b000000, 1,0,0,8'd4,1,1);
`ifdef PRESCALE_EXT_RATIO_EN
    add(0,1,1,6'b000001, 0,0,0,8'd4,0,1);
    add(0,1,0,6'b000000, 0,0,0,8'd4,0,0);
    add(0,1,0,6'b000000, 0,0,0,8'd4,0,0);
    add(0,1,0,6'b000000, 1,1,0,8'd32,1,1);
`else
    add(0,1,1,6'b000001, 1,0,1,8'd4,0,1);
    add(0,1,0,6'b000000, 1,0,0,8'd4,0,0);
    add(0,1,0,6'b000000, 1,0,0,8'd4,0,0);
    add(0,1,0,6'b000000, 1,0,0,8'd4,1,1);
`endif
    add(0,0,0,6'b000000, 1,0,0,R_AFTER_EXT,0,0);
    add(0,0,1,6'b000100, 1,1,0,8'd8,0,0);
    // Ratio 8 -> 2 requested at counter 2; swap on the counter-7 tick
    add(0,1,0,6'b000000, 1,0,0,8'd8,0,1);
    add(0,1,0,6'b000000, 1,0,0,8'd8,0,1);
    add(0,1,0,6'b000000, 1,0,0,8'd8,0,1);
    add(0,1,1,6'b010000, 0,0,0,8'd8,0,1);
    add(0,1,0,6'b000000, 0,0,0,8'd8,0,0);
    add(0,1,0,6'b000000, 0,0,0,8'd8,0,0);
    add(0,1,0,6'b000000, 0,0,0,8'd8,0,0);
    add(0,1,0,6'b000000, 0,0,0,8'd8,0,0);
    add(0,1,0,6'b000000, 1,1,0,8'd2,1,1);
    add(0,1,0,6'b000000, 1,0,0,8'd2,0,0);
    add(0,1,0,6'b000000, 1,0,0,8'd2,1,1);
    // Same-ratio accept, then accept on a wrap edge
    add(0,1,1,6'b010000, 1,1,0,8'd2,0,0);
    add(0,1,0,6'b000000, 1,0,0,8'd2,1,1);
    add(0,1,0,6'b000000, 1,0,0,8'd2,0,0);
    add(0,1,1,6'b001000, 0,0,0,8'd2,1,1);
    add(0,1,0,6'b000000, 0,0,0,8'd2,0,0);
    add(0,1,0,6'b000000, 1,1,0,8'd4,1,1);
    // CLK_EN dropped in PEND applies the pending ratio
    add(0,1,1,6'b100000, 0,0,0,8'd4,0,1);
    add(0,0,0,6'b000000, 1,1,0,8'd1,0,0);
    add(0,0,0,6'b000000, 1,0,0,8'd1,0,0);
    // Accept on the CLK_EN falling edge, then illegal code in IDLE
    add(0,1,0,6'b000000, 1,0,0,8'd1,0,1);
    add(0,0,1,6'b001000, 1,1,0,8'd4,0,0);
    add(0,0,1,6'b000000, 1,0,1,8'd4,0,0);

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], $sformatf("row%0d", i));

    // Reset while a ratio is pending discards it
    t.rst = 0; t.en = 1; t.v = 0; t.ps = 6'b000000; t.exp = {1'b1,1'b0,1'b0,8'd4,1'b0,1'b1};
    apply(t, "pend_rst_run");
    t.v = 1; t.ps = 6'b000100; t.exp = {1'b0,1'b0,1'b0,8'd4,1'b0,1'b1};
    apply(t, "pend_rst_req");
    t.rst = 1; t.v = 0; t.ps = 6'b000000; t.exp = {1'b1,1'b0,1'b0,8'd1,1'b0,1'b0};
    apply(t, "pend_rst_hit");
    t.rst = 0; t.exp = {1'b1,1'b0,1'b0,8'd1,1'b0,1'b1};
    apply(t, "pend_rst_entry");
    t.exp = {1'b1,1'b0,1'b0,8'd1,1'b1,1'b1};
    for (int k = 0; k < 10; k++) apply(t, $sformatf("pend_rst_r1_%0d", k));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/prescale_div_ctrl.md
Name: prescale_div_ctrl

Overview:
Controller for the UART RX oversampling clock divider. It accepts PRESCALE configuration through a valid/ready handshake, decodes it to a divide ratio, and runs the divide counter that produces the divided tick and divided-clock level. A ratio change during operation is held pending and applied only at a period boundary, so no short or stretched period is ever produced. It sits between the register file (PRESCALE source) and the RX sampling logic (DIV_TICK/DIV_OUT consumers).

Parameters:
PRESCALE_WIDTH, 6, width of the PRESCALE configuration field
RATIO_WIDTH, 8, width of DIV_RATIO and the internal divide counter

Ports:
CLK  input  1  system clock; single clock domain
RST  input  1  synchronous, active-high reset
CLK_EN  input  1  divider enable; low forces IDLE
CFG_VALID  input  1  new PRESCALE offered
PRESCALE  input  PRESCALE_WIDTH  one-hot prescale code, sampled on handshake
CFG_READY  output  1  block can accept a configuration
CFG_DONE  output  1  one-cycle pulse when an accepted ratio takes effect
CFG_ERR  output  1  one-cycle pulse when an illegal PRESCALE was accepted
DIV_RATIO  output  RATIO_WIDTH  ratio currently applied
DIV_TICK  output  1  one-cycle pulse at the end of each divided period
DIV_OUT  output  1  divided-clock level

Behaviour:
- Reset (RST sampled high): state IDLE, counter 0, DIV_RATIO=1, pending ratio cleared, DIV_TICK=0, CFG_DONE=0, CFG_ERR=0. DIV_OUT=0 and CFG_READY=1 follow from IDLE. RST mid-operation discards any pending ratio.
- Decode: 6'b100000->1, 6'b010000->2, 6'b001000->4, 6'b000100->8. Any other code is illegal: accepted, CFG_ERR pulses the next cycle, DIV_RATIO and the pending ratio are unchanged, no CFG_DONE. An illegal code never defaults to 1.
- Handshake: accept when CFG_VALID && CFG_READY. CFG_READY = (state != PEND), combinational from state.
- States:
  - IDLE: counter held at 0, DIV_TICK=0.
    - Legal accept: DIV_RATIO updated on the next edge; CFG_DONE pulses the same cycle.
    - CLK_EN sampled 1: go to RUN with counter 0.
  - RUN, applied ratio N, each edge with CLK_EN=1:
    - If counter==N-1: counter<-0, DIV_TICK<-1.
    - Else: counter<-counter+1, DIV_TICK<-0.
    - First tick comes N edges after the RUN-entry edge, then every N edges.
    - Legal accept of a ratio equal to DIV_RATIO: no state change; CFG_DONE pulses the next cycle.
    - Legal accept of a different ratio: store it as pending and go to PEND.
  - PEND: counts exactly as in RUN. On the wrap edge (counter==N-1), DIV_TICK<-1, counter<-0, DIV_RATIO<-pending, CFG_DONE<-1, then go to RUN. The next period uses the new ratio.
- CLK_EN sampled 0 in RUN or PEND: go to IDLE, counter<-0, DIV_TICK<-0. Any pending ratio is applied on that same edge with a CFG_DONE pulse.
- DIV_OUT = (state!=IDLE) && (N==1 || counter < N>>1). Ratio 1 gives a constant high level while running. Even ratios give 50% duty.
- Simultaneous events:
  - Accept in RUN on the wrap edge: the current wrap is unaffected. The new ratio applies at the following wrap.
  - Accept on the edge where CLK_EN falls: go to IDLE and apply the new ratio on the next edge.
  - RST has priority over everything.
- Counter width is RATIO_WIDTH. The counter never exceeds DIV_RATIO-1, so there is no wrap-around hazard.

Optional Feature:
PRESCALE_EXT_RATIO_EN
- Defined: 6'b000010->16 and 6'b000001->32 are also legal.
- Undefined: those two codes are illegal and raise CFG_ERR.

Test Plan:
- Reset, then CLK_EN=1 with no config -> DIV_RATIO=1, DIV_TICK high every cycle from the first edge after RUN entry, DIV_OUT constant 1.
- In IDLE, PRESCALE=6'b001000 accepted, then CLK_EN=1 -> CFG_DONE pulse, DIV_RATIO=4, DIV_TICK every 4th edge, DIV_OUT 1,1,0,0 repeating.
- Running at ratio 8, counter=2, PRESCALE=6'b010000 accepted -> CFG_READY=0 until the tick at counter=7; the next tick comes 2 cycles later; CFG_DONE coincides with the switching tick.
- PRESCALE=6'b000011 accepted while running at 4 -> CFG_ERR pulse, DIV_RATIO stays 4, tick spacing unchanged; with PRESCALE_EXT_RATIO_EN, 6'b000001 -> DIV_RATIO=32.
- In PEND, CLK_EN dropped -> IDLE, pending ratio applied with CFG_DONE, DIV_OUT=0; RST asserted in PEND -> DIV_RATIO=1, pending discarded.
